instr_loader: RTL and testbench

Byte-stream instruction loader for the single-cycle simulator core. Receives a length-prefixed program over a valid/ready byte channel, assembles 32-bit instruction words and writes them into the instruction memory from word address 0 upward. While loading, it holds the core stopped; once the whole program is written, it releases the core. It replaces file preloading as the way a program enters `Instr_Mem`.

---
 rtl/sim_pkg.sv | 17 +
 rtl/instr_loader_if.sv | 30 +++
 rtl/word_assembler.sv | 30 +++
 rtl/instr_loader.sv | 132 +++++++++++++
 tb/tb_instr_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_pkg.sv
// Shared types and constants for the simulator-core instruction loader.
// Checksum option: INSTR_LOADER_CSUM_EN.
package sim_pkg;

    localparam int INSTR_W         = 32;
    localparam int BYTES_PER_INSTR = 4;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bundle of the loader.
// The loader is the slave side; the byte source is the master.
interface instr_loader_if
    import sim_pkg::*;
#(
    parameter int ADDR_W = 5
);

    logic [7:0]         s_data_i;
    logic               s_valid_i;
    logic               s_ready_o;
    logic               mem_we_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [INSTR_W-1:0] mem_data_o;
    logic               run_o;
    logic               err_o;

    modport slave (
        input  s_data_i, s_valid_i,
        output s_ready_o, mem_we_o, mem_addr_o, mem_data_o,
        output run_o, err_o
    );

    modport master (
        output s_data_i, s_valid_i,
        input  s_ready_o, mem_we_o, mem_addr_o, mem_data_o,
        input  run_o, err_o
    );

endinterface

// File: rtl/word_assembler.sv
// Packs MSB-first bytes into instruction words.
// word_valid pulses with the completed word on the last byte's accept.
module word_assembler
    import sim_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               byte_en,
    input  logic [7:0]         byte_in,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [1:0]         cnt;
    logic [INSTR_W-9:0] shreg;

    assign word       = {shreg, byte_in};
    assign word_valid = byte_en && (cnt == 2'(BYTES_PER_INSTR - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_en) begin
            cnt   <= cnt + 2'd1;
            shreg <= word[INSTR_W-9:0];
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Length-prefixed byte-stream loader into instruction memory; holds core until done.
// Define INSTR_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module instr_loader
    import sim_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_loader_if.slave  bus
);

    loader_state_t      state;
    logic [7:0]         len_hi;
    logic [15:0]        len;
    logic [ADDR_W:0]    idx;
    logic               rdy_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] data_q;
    logic               run_q;
    logic               err_q;

    logic               xfer;
    logic [15:0]        len_n;
    logic               last_word;
    logic               wv;
    logic [INSTR_W-1:0] wd;

    assign xfer      = bus.s_valid_i && rdy_q;
    assign len_n     = {len_hi, bus.s_data_i};
    assign last_word = (16'(idx) + 16'd1) == len;

    word_assembler u_asm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .byte_en    (xfer && (state == DATA)),
        .byte_in    (bus.s_data_i),
        .word_valid (wv),
        .word       (wd)
    );

`ifdef INSTR_LOADER_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            csum <= '0;
        else if (xfer)
            csum <= csum ^ bus.s_data_i;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= LEN_HI;
            len_hi <= '0;
            len    <= '0;
            idx    <= '0;
            rdy_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            run_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (wv) begin
                we_q   <= 1'b1;
                addr_q <= idx[ADDR_W-1:0];
                data_q <= wd;
                idx    <= idx + 1'b1;
            end
            unique case (state)
                LEN_HI: if (xfer) begin
                    len_hi <= bus.s_data_i;
                    state  <= LEN_LO;
                end
                LEN_LO: if (xfer) begin
                    len <= len_n;
                    if (len_n == 16'd0) begin
`ifdef INSTR_LOADER_CSUM_EN
                        state <= CSUM;
`else
                        state <= DONE;
                        rdy_q <= 1'b0;
                        run_q <= 1'b1;
`endif
                    end else if (len_n > 16'(DEPTH)) begin
                        state <= ERR;
                        rdy_q <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                // run_o follows one cycle later, behind the final write strobe
                DATA: if (wv && last_word) begin
`ifdef INSTR_LOADER_CSUM_EN
                    state <= CSUM;
`else
                    state <= DONE;
                    rdy_q <= 1'b0;
`endif
                end
`ifdef INSTR_LOADER_CSUM_EN
                CSUM: if (xfer) begin
                    rdy_q <= 1'b0;
                    if (bus.s_data_i == csum) begin
                        state <= DONE;
                        run_q <= 1'b1;
                    end else begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end
                end
`endif
                DONE: run_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.s_ready_o  = rdy_q;
    assign bus.mem_we_o   = we_q;
    assign bus.mem_addr_o = addr_q;
    assign bus.mem_data_o = data_q;
    assign bus.run_o      = run_q;
    assign bus.err_o      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: length/data streams, gaps, overflow, reset.
// Also covers the checksum byte when built with INSTR_LOADER_CSUM_EN.
module tb_instr_loader;

`ifdef INSTR_LOADER_CSUM_EN
    localparam int RUN_DLY = 1;
`else
    localparam int RUN_DLY = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_loader_if #(.ADDR_W(5)) bus ();

    instr_loader #(
        .ADDR_W (5),
        .DEPTH  (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int data_acc = 0;
    int wr_n = 0;
    int run_cyc = -1;
    int err_cyc = -1;
    logic [7:0]  tb_csum = 8'h00;
    logic [4:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cyc  [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we_o && wr_n < 64) begin
            wr_addr[wr_n] <= bus.mem_addr_o;
            wr_data[wr_n] <= bus.mem_data_o;
            wr_cyc[wr_n]  <= cyc;
            wr_n          <= wr_n + 1;
        end
        if (bus.run_o && run_cyc < 0) run_cyc <= cyc;
        if (bus.err_o && err_cyc < 0) err_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_n    = 0;
        run_cyc = -1;
        err_cyc = -1;
        tb_csum = 8'h00;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 8'h00;
        settle(2);
        clear_log();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.s_data_i  = b;
        bus.s_valid_i = 1'b1;
        while (!bus.s_ready_o && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready_o)
            check("rdy_wait", 32'(bus.s_ready_o), 32'd1);
        else
            acc_cyc = cyc;
        tb_csum = tb_csum ^ b;
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        settle(gap);
    endtask

    task automatic send_prog(input logic [7:0] s[$], input int gap);
        foreach (s[i]) send_byte(s[i], gap);
        data_acc = acc_cyc;
    endtask

    task automatic send_tail();
`ifdef INSTR_LOADER_CSUM_EN
        logic [7:0] c;
        c = tb_csum;
        send_byte(c, 0);
`endif
    endtask

    task automatic check_prog2(input string tag);
        check({tag, "_nwr"}, 32'(wr_n), 32'd2);
        check({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
        check({tag, "_d0"}, wr_data[0], 32'h20010005);
        check({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
        check({tag, "_d1"}, wr_data[1], 32'h8C220004);
        check({tag, "_we_lat"}, 32'(wr_cyc[1] - data_acc), 32'd1);
        check({tag, "_run_lat"}, 32'(run_cyc - acc_cyc), 32'(RUN_DLY));
        check({tag, "_rdy"}, 32'(bus.s_ready_o), 32'd0);
        check({tag, "_err"}, 32'(bus.err_o), 32'd0);
    endtask

    logic [7:0] q[$];

    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 8'h00;
        settle(2);
        check("rst_rdy", 32'(bus.s_ready_o), 32'd1);
        check("rst_we", 32'(bus.mem_we_o), 32'd0);
        check("rst_addr", 32'(bus.mem_addr_o), 32'd0);
        check("rst_data", bus.mem_data_o, 32'd0);
        check("rst_run", 32'(bus.run_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);

        // N = 0
        apply_reset();
        send_prog('{8'h00, 8'h00}, 0);
        send_tail();
        settle(4);
        check("n0_nwr", 32'(wr_n), 32'd0);
        check("n0_run_lat", 32'(run_cyc - acc_cyc), 32'd1);
        check("n0_run", 32'(bus.run_o), 32'd1);
        check("n0_rdy", 32'(bus.s_ready_o), 32'd0);

        // N = 2 back-to-back, then with 3-cycle gaps
        q = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
              8'h8C, 8'h22, 8'h00, 8'h04};
        apply_reset();
        send_prog(q, 0);
        send_tail();
        settle(4);
        check_prog2("b2b");

        apply_reset();
        send_prog(q, 3);
        send_tail();
        settle(4);
        check_prog2("gap");

        // N = 33 exceeds capacity
        apply_reset();
        send_prog('{8'h00, 8'h21}, 0);
        settle(3);
        check("ovf_err_lat", 32'(err_cyc - acc_cyc), 32'd1);
        check("ovf_err", 32'(bus.err_o), 32'd1);
        check("ovf_run", 32'(bus.run_o), 32'd0);
        check("ovf_rdy", 32'(bus.s_ready_o), 32'd0);
        bus.s_data_i  = 8'hAA;
        bus.s_valid_i = 1'b1;
        settle(4);
        bus.s_valid_i = 1'b0;
        check("ovf_nwr", 32'(wr_n), 32'd0);

        // N = 32 fills memory exactly; word i = i
        apply_reset();
        q = '{8'h00, 8'h20};
        for (int i = 0; i < 32; i++) q = {q, 8'h00, 8'h00, 8'h00, 8'(i)};
        send_prog(q, 0);
        send_tail();
        settle(4);
        check("full_nwr", 32'(wr_n), 32'd32);
        check("full_a31", 32'(wr_addr[31]), 32'd31);
        check("full_d31", wr_data[31], 32'd31);
        check("full_d17", wr_data[17], 32'd17);
        check("full_run", 32'(bus.run_o), 32'd1);
        check("full_err", 32'(bus.err_o), 32'd0);

        // reset mid-word, then fresh N = 1 stream
        apply_reset();
        send_prog('{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                    8'hFF, 8'hFF}, 0);
        check("mid_data", bus.mem_data_o, 32'h20010005);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(bus.s_ready_o), 32'd1);
        check("mid_rst_data", bus.mem_data_o, 32'd0);
        check("mid_rst_we", 32'(bus.mem_we_o), 32'd0);
        settle(2);
        clear_log();
        rst_n = 1'b1;
        @(negedge clk);
        send_prog('{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0);
        send_tail();
        settle(4);
        check("mid_nwr", 32'(wr_n), 32'd1);
        check("mid_a0", 32'(wr_addr[0]), 32'd0);
        check("mid_d0", wr_data[0], 32'hFFFFFFFF);
        check("mid_run", 32'(bus.run_o), 32'd1);

`ifdef INSTR_LOADER_CSUM_EN
        // XOR of 00 01 00 00 00 01 is 00
        apply_reset();
        send_prog('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01}, 0);
        send_byte(8'h00, 0);
        settle(3);
        check("cs_ok_run_lat", 32'(run_cyc - acc_cyc), 32'd1);
        check("cs_ok_run", 32'(bus.run_o), 32'd1);
        check("cs_ok_err", 32'(bus.err_o), 32'd0);

        apply_reset();
        send_prog('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01}, 0);
        send_byte(8'h01, 0);
        settle(3);
        check("cs_bad_err", 32'(bus.err_o), 32'd1);
        check("cs_bad_run", 32'(bus.run_o), 32'd0);
        check("cs_bad_nwr", 32'(wr_n), 32'd1);
        check("cs_bad_rdy", 32'(bus.s_ready_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
